// File: rtl/ma_dm_load.sv
// Datamover load path: reads byte_to_trans bytes from AXI memory with INCR bursts
// and writes each returned beat into local BRAM, pulsing done after the last write.
module ma_dm_load #(
  parameter int AXI_ADDR_WIDTH   = 36,
  parameter int BRAM_ADDR_WIDTH  = 10,
  parameter int BYTE_TRANS_WIDTH = 15,
  parameter int DATA_WIDTH       = 128,
  parameter int MAX_BURST_LEN    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [AXI_ADDR_WIDTH-1:0]   src_axi_addr,
  input  logic [BRAM_ADDR_WIDTH-1:0]  dst_bram_addr,
  input  logic [BYTE_TRANS_WIDTH-1:0] byte_to_trans,
  output logic                        done,
  output logic                        err,
  output logic                        busy,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  output logic                        bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_addr,
  output logic [DATA_WIDTH-1:0]       bram_wdata
);

  localparam int BPB      = DATA_WIDTH / 8;
  localparam int BPB_LOG2 = $clog2(BPB);
  localparam int BEATS_W  = BYTE_TRANS_WIDTH - BPB_LOG2 + 1;
  localparam logic [12:0] PAGE_BYTES = 13'h1000;

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t state, state_n;

  logic [AXI_ADDR_WIDTH-1:0]  addr;
  logic [BRAM_ADDR_WIDTH-1:0] waddr;
  logic [BEATS_W-1:0]         beats_rem;
  logic [BEATS_W-1:0]         beats_in;
  logic [BYTE_TRANS_WIDTH:0]  bytes_pad;
  logic [12:0]                room;
  logic [12:0]                len;
  logic                       accept;
  logic                       ar_hs;
  logic                       r_hs;

  // Round the byte count up to whole beats; the partial tail beat is moved in full.
  always_comb begin
    bytes_pad = {1'b0, byte_to_trans} + (BYTE_TRANS_WIDTH+1)'(BPB - 1);
    beats_in  = BEATS_W'(bytes_pad >> BPB_LOG2);
  end

  // Burst length is capped by remaining beats, MAX_BURST_LEN and the 4 KB page end.
  always_comb begin
    room = (PAGE_BYTES - {1'b0, addr[11:0]}) >> BPB_LOG2;
    len  = room;
    if (len > 13'(MAX_BURST_LEN)) len = 13'(MAX_BURST_LEN);
    if (32'(beats_rem) < 32'(len)) len = 13'(beats_rem);
  end

  assign accept = start && (state == IDLE) && !busy;
  assign ar_hs  = (state == AR) && m_axi_arready;
  assign r_hs   = (state == R) && m_axi_rvalid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = 3'(BPB_LOG2);
    m_axi_arburst = 2'b01;
    case (state)
      IDLE: begin
        if (accept) state_n = (beats_in == '0) ? DONE : AR;
      end
      AR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = addr;
        m_axi_arlen   = 8'(len - 13'd1);
        if (m_axi_arready) state_n = R;
      end
      R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) state_n = (beats_rem == '0) ? DONE : AR;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      waddr      <= '0;
      beats_rem  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      // done is registered so it lands the cycle after the final bram_we.
      done    <= (state == DONE);
      bram_we <= r_hs;
      if (accept) begin
        addr      <= src_axi_addr;
        waddr     <= dst_bram_addr;
        beats_rem <= beats_in;
        err       <= 1'b0;
        busy      <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (ar_hs) begin
        addr      <= addr + (AXI_ADDR_WIDTH'(len) << BPB_LOG2);
        beats_rem <= beats_rem - BEATS_W'(len);
      end
      if (r_hs) begin
        bram_addr  <= waddr;
        bram_wdata <= m_axi_rdata;
        waddr      <= waddr + BRAM_ADDR_WIDTH'(1);
        if (m_axi_rresp != 2'b00) err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ma_dm_load.md
Name: ma_dm_load

Overview:
- Datamover-side (slave) endpoint of the datamover command interface, load path only.
- On a start command, copies byte_to_trans bytes from AXI memory at src_axi_addr into the local BRAM at dst_bram_addr.
- Issues AXI4 INCR read bursts and writes each returned beat into the BRAM. Pulses done when the last BRAM write has been issued.
- src_bram_addr and dst_axi_addr belong to the store path; this block does not consume them.

Parameters:
- AXI_ADDR_WIDTH, 36, AXI byte address width.
- BRAM_ADDR_WIDTH, 10, BRAM word address width (one word = one AXI beat).
- BYTE_TRANS_WIDTH, 15, byte count width.
- DATA_WIDTH, 128, AXI/BRAM data width in bits. BPB = DATA_WIDTH/8 bytes per beat.
- MAX_BURST_LEN, 16, maximum beats per AXI burst (1..256).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  command strobe (datamover_if slave).
- src_axi_addr  in  AXI_ADDR_WIDTH  source byte address, BPB-aligned.
- dst_bram_addr  in  BRAM_ADDR_WIDTH  first BRAM word address.
- byte_to_trans  in  BYTE_TRANS_WIDTH  byte count.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky read-error flag; cleared on the next accepted start.
- busy  out  1  high from accepted start until the done cycle inclusive.
- m_axi_araddr  out  AXI_ADDR_WIDTH  burst address.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  constant log2(BPB).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arvalid  out  1  / m_axi_arready  in  1  AR handshake.
- m_axi_rdata  in  DATA_WIDTH  / m_axi_rresp  in  2  / m_axi_rlast  in  1  read data.
- m_axi_rvalid  in  1  / m_axi_rready  out  1  R handshake.
- bram_we  out  1  / bram_addr  out  BRAM_ADDR_WIDTH  / bram_wdata  out  DATA_WIDTH  BRAM write port.

Behaviour:
- Reset: state IDLE. done, err, busy, arvalid, rready, bram_we = 0. araddr, arlen, bram_addr, bram_wdata = 0. Reset mid-transfer abandons the transfer; no done is produced.
- Command capture: start is accepted only in IDLE. In the accept cycle the block latches:
  - addr = src_axi_addr
  - waddr = dst_bram_addr
  - beats = ceil(byte_to_trans / BPB); a partial last beat is written in full.
  - start while busy is ignored.
- States:
  - IDLE: on accepted start with beats==0 -> DONE. Otherwise -> AR.
  - AR: arvalid=1, araddr=addr, arlen=len-1.
    - len = min(beats remaining, MAX_BURST_LEN, (4096 - addr[11:0]) / BPB). No burst crosses a 4 KB boundary.
    - araddr and arlen are held stable while arvalid && !arready.
    - On handshake -> R. addr += len*BPB.
  - R: rready=1.
    - Each rvalid&&rready captures rdata and asserts bram_we next cycle, with bram_addr=waddr and bram_wdata=captured data. waddr increments by 1 and wraps modulo 2^BRAM_ADDR_WIDTH.
    - On the beat with rlast: if beats remaining == 0 -> DONE, else -> AR.
  - DONE: done=1 for exactly one cycle, in the cycle after the final bram_we. -> IDLE.
- Exactly one burst outstanding at a time. arvalid and rready are never high in the same cycle.
- A zero-byte command pulses done 2 cycles after start, with no AXI or BRAM activity.
- rresp != 2'b00 on any beat sets err. The beat is still written and the transfer still runs to completion with done.
- rlast is trusted as the burst terminator; beats are counted per burst, and the block does not check rlast against the count.

Test Plan:
- Nominal: BPB=16, src=0x1000, dst=0x020, bytes=256, arready/rvalid always 1 -> one AR with arlen=15; 16 bram_we at addr 0x020..0x02F carrying matching data; done pulse once; err=0.
- Split: bytes=300, src=0x0 -> 19 beats -> AR#1 araddr=0x0 arlen=15, AR#2 araddr=0x100 arlen=2; bram addr dst..dst+18; single done.
- 4 KB boundary: src=0xFC0, bytes=128 -> AR#1 araddr=0xFC0 arlen=3, AR#2 araddr=0x1000 arlen=3; 8 writes.
- Backpressure and wrap: arready low 5 cycles, rvalid toggling every other cycle, dst=0x3FE, bytes=64 -> AR fields held stable; writes to 0x3FE, 0x3FF, 0x000, 0x001; start pulses during the transfer ignored.
- Error and zero-length: SLVERR on beat 2 of 4 -> all 4 written, err=1, done pulse; next start with bytes=0 clears err, done 2 cycles later, no arvalid.
- Reset mid-burst: assert rst after beat 3 of 16 -> all outputs 0 next cycle, no done; a new command then completes normally.
